edge_pulse_gen: RTL
===================

// Module: edge_pulse_gen
// PURPOSE
//  Multi-channel, glitch-free edge-to-pulse generator. Each channel detects a
//  selectable edge (rise/fall/both) on an asynchronous input and emits a
//  registered pulse of PULSE_LEN clocks. An optional lockout window follows.
//  Sits between raw buttons/strobes and synchronous control logic.
// PARAMETERS
//  N_CH        4  number of independent channels
//  SYNC_STAGES 2  input synchroniser flops per channel (0 = input already synchronous)
//  PULSE_LEN   1  output pulse width in clocks (>=1)
//  GAP_LEN     0  lockout clocks after each pulse; edges ignored (0 = none)
//  RETRIG      0  1: a qualifying edge during PULSE reloads the width counter
// PORTS
//  clk      in   1         system clock, rising edge
//  clr      in   1         asynchronous reset, active-high
//  en       in   N_CH      per-channel enable
//  mode     in   2*N_CH    per-channel edge select, ch i = mode[2i+1:2i]
//  in       in   N_CH      raw inputs, may be asynchronous
//  ovr_clr  in   N_CH      clears sticky ovr bit of channel
//  out      out  N_CH      pulse outputs, driven directly from flops
//  busy     out  N_CH      1 while channel is in PULSE or GAP
//  ovr      out  N_CH      sticky: a qualifying edge was dropped
// BEHAVIOUR
//  Reset (clr=1, async): all sync flops, prev, state=IDLE, counter=0, out=0,
//   busy=0, ovr=0.
//  mode: 00 OFF, 01 RISE, 10 FALL, 11 BOTH.
//  in_s = in after SYNC_STAGES flops; prev = in_s delayed 1 clk.
//   rise = in_s & ~prev; fall = ~in_s & prev.
//   trig = en & ((mode[0] & rise) | (mode[1] & fall)).
//  Input held high through reset release gives rise=1 on first valid in_s.
//  Per-channel FSM (Moore; out and busy are registered outputs):
//   IDLE : trig -> PULSE, cnt=PULSE_LEN-1, out<=1.
//   PULSE: cnt==0 -> GAP (cnt=GAP_LEN-1) if GAP_LEN>0, else IDLE; out<=0.
//          cnt!=0 -> cnt-1. trig & RETRIG -> cnt=PULSE_LEN-1, stay.
//          trig & !RETRIG -> ignored, ovr<=1.
//          trig on the exit cycle (cnt==0), GAP_LEN=0, RETRIG=0 -> back to
//          PULSE: out stays 1, cnt=PULSE_LEN-1, ovr unchanged.
//   GAP  : out=0; cnt==0 -> IDLE, else cnt-1; trig -> ignored, ovr<=1.
//  Latency: edge on in -> out=1 after SYNC_STAGES+1 rising clk edges.
//  en=0: channel forced to IDLE next clk (out=0, busy=0, cnt=0).
//   prev keeps tracking, so no false edge on re-enable.
//  mode change mid-PULSE/GAP: current pulse/gap completes; new mode applies
//   to the next trig evaluation.
//  ovr: set has priority over ovr_clr in the same cycle.
//  cnt width = $clog2(max(PULSE_LEN,GAP_LEN)+1); no wrap, saturates at 0.
//  Channels are fully independent; no shared state.
//  clr asserted mid-pulse: out drops asynchronously; no partial pulse resumes.
// STRUCTURE
//  Package edge_pulse_pkg: mode encodings (MODE_OFF/RISE/FALL/BOTH),
//   state encoding (ST_IDLE/ST_PULSE/ST_GAP), width function for cnt.
//  Sub-module edge_pulse_ch: one channel (sync chain, edge detect, FSM,
//   counter, ovr). Top level is a generate loop over N_CH, slicing mode.
// TESTING
//  1 N_CH=1,SYNC=2,LEN=1,mode=01: in 0->1 at cyc 10 -> out=1 only in cyc 13; falling edge -> no pulse.
//  2 mode=11,LEN=3: in 0->1 cyc 10, 1->0 cyc 20 -> out high cyc 13-15 and 23-25; ovr=0.
//  3 LEN=4,RETRIG=0,GAP=2: rise, then fall 2 clks later (mode=11) -> single 4-clk pulse, busy 6 clks, ovr=1; ovr_clr -> ovr=0.
//  4 Same with RETRIG=1,GAP=0 -> pulse extended: out high 6 clks total, ovr=0.
//  5 en dropped in 2nd clk of 4-clk pulse -> out=0 next clk; re-enable with in high -> no pulse.
//  6 clr pulsed mid-pulse (async, between edges) -> out=0 immediately; in held high across release -> one pulse SYNC_STAGES+1 clks later.

Source files
------------

// File: rtl/edge_pulse_pkg.sv
// Shared encodings and helpers for the edge-to-pulse generator.
// Mode bit 0 selects rising edges, bit 1 selects falling edges.
package edge_pulse_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Counter must hold the larger of the two reload values without wrapping.
    function automatic int cnt_width(input int pulse_len, input int gap_len);
        int m;
        m = (pulse_len > gap_len) ? pulse_len : gap_len;
        if (m < 1) begin
            return 1;
        end
        return $clog2(m + 1);
    endfunction

    function automatic logic edge_qualifies(input logic [1:0] mode,
                                            input logic       rise,
                                            input logic       fall);
        logic q;
        case (mode)
            MODE_OFF:  q = 1'b0;
            MODE_RISE: q = rise;
            MODE_FALL: q = fall;
            MODE_BOTH: q = rise | fall;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/edge_pulse_ch.sv
// One edge-to-pulse channel: synchroniser, edge detector, pulse/lockout FSM
// with down-counter, and a sticky overrun flag.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | waiting for a qualifying edge, out=0, busy=0
//  ST_PULSE | driving out=1 until the width counter reaches 0
//  ST_GAP   | lockout after a pulse, out=0, busy=1, edges are dropped
module edge_pulse_ch
    import edge_pulse_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int GAP_LEN     = 0,
    parameter int RETRIG      = 0
) (
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [1:0] mode_i,
    input  logic       in_i,
    input  logic       ovr_clr_i,
    output logic       out_o,
    output logic       busy_o,
    output logic       ovr_o
);

    localparam int              CW         = cnt_width(PULSE_LEN, GAP_LEN);
    localparam logic [CW-1:0]   PULSE_LOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0]   GAP_LOAD   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;
    localparam bit              HAS_GAP    = (GAP_LEN > 0);
    localparam bit              DO_RETRIG  = (RETRIG != 0);

    logic          in_s;
    logic          prev_q;
    logic          rise;
    logic          fall;
    logic          trig;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          out_q,   out_d;
    logic          busy_q,  busy_d;
    logic          ovr_q,   ovr_d;
    logic          ovr_set;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign in_s = in_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk_i or posedge clr_i) begin
                if (clr_i) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= in_i;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign in_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // prev tracks regardless of enable so re-enabling never sees a stale edge.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= in_s;
        end
    end

    assign rise = in_s & ~prev_q;
    assign fall = ~in_s & prev_q;
    assign trig = en_i & edge_qualifies(mode_i, rise, fall);

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovr_set = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        state_d = ST_PULSE;
                        cnt_d   = PULSE_LOAD;
                    end
                end
                ST_PULSE: begin
                    if (trig && DO_RETRIG) begin
                        cnt_d = PULSE_LOAD;
                    end else if (cnt_q == '0) begin
                        if (HAS_GAP) begin
                            state_d = ST_GAP;
                            cnt_d   = GAP_LOAD;
                            ovr_set = trig;
                        end else if (trig) begin
                            // back-to-back pulse: out stays high, nothing dropped
                            cnt_d = PULSE_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d   = cnt_q - CW'(1);
                        ovr_set = trig;
                    end
                end
                ST_GAP: begin
                    ovr_set = trig;
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        out_d  = (state_d == ST_PULSE);
        busy_d = (state_d != ST_IDLE);
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    assign out_o  = out_q;
    assign busy_o = busy_q;
    assign ovr_o  = ovr_q;

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel edge-to-pulse generator; each channel is an independent
// edge_pulse_ch with its own two-bit slice of the mode bus.
module edge_pulse_gen
    import edge_pulse_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int GAP_LEN     = 0,
    parameter int RETRIG      = 0
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic [N_CH-1:0]   en_i,
    input  logic [2*N_CH-1:0] mode_i,
    input  logic [N_CH-1:0]   in_i,
    input  logic [N_CH-1:0]   ovr_clr_i,
    output logic [N_CH-1:0]   out_o,
    output logic [N_CH-1:0]   busy_o,
    output logic [N_CH-1:0]   ovr_o
);

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            edge_pulse_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .PULSE_LEN   (PULSE_LEN),
                .GAP_LEN     (GAP_LEN),
                .RETRIG      (RETRIG)
            ) u_ch (
                .clk_i     (clk_i),
                .clr_i     (clr_i),
                .en_i      (en_i[i]),
                .mode_i    (mode_i[2*i+1:2*i]),
                .in_i      (in_i[i]),
                .ovr_clr_i (ovr_clr_i[i]),
                .out_o     (out_o[i]),
                .busy_o    (busy_o[i]),
                .ovr_o     (ovr_o[i])
            );
        end
    endgenerate

endmodule
